// File: rtl/cc_serializer_sched_if.sv
// Bundles the hit, refill, FIFO-write and serializer-monitor signals of the line scheduler.
// No logic of its own. Timing is set by cc_serializer_sched.
// Backpressure is carried by the ready signals and the FIFO full/afull flags.
interface cc_serializer_sched_if;
    logic         hit_valid_i;
    logic [517:0] hit_data_i;
    logic         hit_ready_o;
    logic         miss_valid_i;
    logic [517:0] miss_data_i;
    logic         miss_ready_o;
    logic         fifo_full_i;
    logic         fifo_afull_i;
    logic         fifo_wren_o;
    logic [517:0] fifo_wdata_o;
    logic         rvalid_i;
    logic         rready_i;
    logic         rlast_i;

    // Scheduler side
    modport slave (
        input  hit_valid_i, hit_data_i,
        output hit_ready_o,
        input  miss_valid_i, miss_data_i,
        output miss_ready_o,
        input  fifo_full_i, fifo_afull_i,
        output fifo_wren_o, fifo_wdata_o,
        input  rvalid_i, rready_i, rlast_i
    );

    // Requester, FIFO and serializer side
    modport master (
        output hit_valid_i, hit_data_i,
        input  hit_ready_o,
        output miss_valid_i, miss_data_i,
        input  miss_ready_o,
        output fifo_full_i, fifo_afull_i,
        input  fifo_wren_o, fifo_wdata_o,
        output rvalid_i, rready_i, rlast_i
    );
endinterface

// File: rtl/cc_serializer_sched.sv
// Round-robin scheduler: hit-return vs miss-refill lines into the serializer FIFO.
// Latency: the accept cycle is followed by the registered FIFO write on the next cycle.
// Backpressure: grants stop on FIFO full, afull with a pending write, or when the in-flight credit limit is reached.
module cc_serializer_sched #(
    parameter int MAX_LINES = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    cc_serializer_sched_if.slave bus,
    output logic [CNT_W-1:0]     inflight_o,
    output logic                 idle_o,
    output logic                 err_o
);
    localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_LINES);

    logic           grant_en;
    logic           pick_hit;
    logic           grant;
    logic           last_was_miss;
    logic           inc;
    logic           dec;
    logic           cnt_ovf;
    logic           cnt_unf;
    logic           err_set;
    logic [517:0]   win_data;
    logic [CNT_W:0] pending;

    // Grant enable from registered state only, then arbitration between the two paths
    always_comb begin
        pending  = {1'b0, inflight_o} + {{CNT_W{1'b0}}, bus.fifo_wren_o};
        grant_en = !bus.fifo_full_i
                && !(bus.fifo_afull_i && bus.fifo_wren_o)
                && (pending < MAX_C);
        // Hit wins when alone, or on a tie when the previous grant went to miss
        pick_hit = bus.hit_valid_i && (!bus.miss_valid_i || last_was_miss);
        bus.hit_ready_o  = grant_en && pick_hit;
        bus.miss_ready_o = grant_en && bus.miss_valid_i && !pick_hit;
        grant    = bus.hit_ready_o || bus.miss_ready_o;
        win_data = pick_hit ? bus.hit_data_i : bus.miss_data_i;
    end

    // Registered FIFO write port and round-robin pointer; data holds between writes
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fifo_wren_o  <= 1'b0;
            bus.fifo_wdata_o <= '0;
            last_was_miss    <= 1'b1;
        end else begin
            bus.fifo_wren_o <= grant;
            if (grant) begin
                bus.fifo_wdata_o <= win_data;
                last_was_miss    <= !pick_hit;
            end
        end
    end

    // Credit events: a write adds a line, a serializer last-beat handshake retires one
    always_comb begin
        inc     = bus.fifo_wren_o;
        dec     = bus.rvalid_i && bus.rready_i && bus.rlast_i;
        cnt_ovf = inc && !dec && ({1'b0, inflight_o} == MAX_C);
        cnt_unf = dec && !inc && (inflight_o == '0);
        err_set = (grant && (win_data[514:512] != 3'd0))
               || (bus.fifo_wren_o && bus.fifo_full_i)
               || cnt_ovf || cnt_unf;
    end

    // In-flight counter, saturating at both ends
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_o <= '0;
        end else if (inc && !dec && !cnt_ovf) begin
            inflight_o <= inflight_o + 1'b1;
        end else if (dec && !inc && !cnt_unf) begin
            inflight_o <= inflight_o - 1'b1;
        end
    end

    // Sticky protocol error, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (err_set) begin
            err_o <= 1'b1;
        end
    end

    assign idle_o = (inflight_o == '0) && !bus.fifo_wren_o;
endmodule

// File: tb/tb_cc_serializer_sched.sv
// Directed bench for cc_serializer_sched: reset, latency, round-robin, credit limit, FIFO flags, errors.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Expected values are hand-derived constants for MAX_LINES=4.
module tb_cc_serializer_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] inflight;
    logic       idle;
    logic       err;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [517:0] exp_prev;
    logic [517:0] d13;

    cc_serializer_sched_if bus_if ();

    cc_serializer_sched #(.MAX_LINES(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if.slave),
        .inflight_o (inflight),
        .idle_o     (idle),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [517:0] mk(input logic [5:0] off, input logic [31:0] seed);
        return {off, {16{seed}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [517:0] obs, input logic [517:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rl(input logic v);
        bus_if.rvalid_i = v;
        bus_if.rready_i = v;
        bus_if.rlast_i  = v;
    endtask

    initial begin
        bus_if.hit_valid_i  = 1'b0;
        bus_if.hit_data_i   = '0;
        bus_if.miss_valid_i = 1'b0;
        bus_if.miss_data_i  = '0;
        bus_if.fifo_full_i  = 1'b0;
        bus_if.fifo_afull_i = 1'b0;
        set_rl(1'b0);

        // Reset values
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_wren", bus_if.fifo_wren_o, 1'b0);
        chk("rst_wdata", bus_if.fifo_wdata_o, '0);
        chk("rst_inflight", inflight, 3'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_idle", idle, 1'b1);

        // Single hit line, offset 16
        bus_if.hit_valid_i = 1'b1;
        bus_if.hit_data_i  = mk(6'd16, 32'h1111_0001);
        #1;
        chk("t1_hit_ready", bus_if.hit_ready_o, 1'b1);
        chk("t1_miss_ready", bus_if.miss_ready_o, 1'b0);
        tick();
        bus_if.hit_valid_i = 1'b0;
        chk("t1_wren", bus_if.fifo_wren_o, 1'b1);
        chk("t1_wdata", bus_if.fifo_wdata_o, mk(6'd16, 32'h1111_0001));
        #1;
        chk("t1_ready_novalid", bus_if.hit_ready_o, 1'b0);
        tick();
        chk("t1_wren_drop", bus_if.fifo_wren_o, 1'b0);
        chk("t1_inflight1", inflight, 3'd1);
        chk("t1_not_idle", idle, 1'b0);
        chk("t1_wdata_hold", bus_if.fifo_wdata_o, mk(6'd16, 32'h1111_0001));
        set_rl(1'b1);
        tick();
        set_rl(1'b0);
        chk("t1_inflight0", inflight, 3'd0);
        chk("t1_idle", idle, 1'b1);
        chk("t1_err", err, 1'b0);

        // Round-robin with both paths valid; rlast returned from the third cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_prev = '0;
        for (int i = 0; i < 6; i++) begin
            bus_if.hit_valid_i  = 1'b1;
            bus_if.miss_valid_i = 1'b1;
            bus_if.hit_data_i   = mk(6'd0, 32'hA0 + i);
            bus_if.miss_data_i  = mk(6'd8, 32'hB0 + i);
            set_rl(i >= 2);
            #1;
            chk("t2_hit_ready", bus_if.hit_ready_o, (i % 2) == 0);
            chk("t2_miss_ready", bus_if.miss_ready_o, (i % 2) == 1);
            if (i >= 1) begin
                chk("t2_wren", bus_if.fifo_wren_o, 1'b1);
                chk("t2_wdata", bus_if.fifo_wdata_o, exp_prev);
            end
            exp_prev = ((i % 2) == 0) ? mk(6'd0, 32'hA0 + i) : mk(6'd8, 32'hB0 + i);
            tick();
        end
        bus_if.hit_valid_i  = 1'b0;
        bus_if.miss_valid_i = 1'b0;
        #1;
        chk("t2_last_wren", bus_if.fifo_wren_o, 1'b1);
        chk("t2_last_wdata", bus_if.fifo_wdata_o, exp_prev);
        tick();
        chk("t2_inflight_same", inflight, 3'd1);
        tick();
        set_rl(1'b0);
        chk("t2_inflight_drain", inflight, 3'd0);
        chk("t2_err", err, 1'b0);

        // Credit limit: six hit lines offered, no rlast
        for (int i = 0; i < 6; i++) begin
            bus_if.hit_valid_i = 1'b1;
            bus_if.hit_data_i  = mk(6'd24, 32'hC0 + i);
            #1;
            chk("t3_hit_ready", bus_if.hit_ready_o, i < 4);
            tick();
        end
        chk("t3_ready_blocked", bus_if.hit_ready_o, 1'b0);
        chk("t3_inflight4", inflight, 3'd4);
        chk("t3_wren_idle", bus_if.fifo_wren_o, 1'b0);
        set_rl(1'b1);
        tick();
        set_rl(1'b0);
        chk("t3_regrant", bus_if.hit_ready_o, 1'b1);
        tick();
        chk("t3_one_only", bus_if.hit_ready_o, 1'b0);
        chk("t3_wren", bus_if.fifo_wren_o, 1'b1);
        chk("t3_wdata", bus_if.fifo_wdata_o, mk(6'd24, 32'hC5));
        bus_if.hit_valid_i = 1'b0;
        set_rl(1'b1);
        repeat (4) tick();
        set_rl(1'b0);
        chk("t3_inflight_drain", inflight, 3'd0);
        chk("t3_err", err, 1'b0);

        // FIFO almost-full with pending write, then full
        bus_if.hit_valid_i = 1'b1;
        bus_if.hit_data_i  = mk(6'd32, 32'hD0);
        #1;
        chk("t4_grant_a", bus_if.hit_ready_o, 1'b1);
        tick();
        bus_if.fifo_afull_i = 1'b1;
        #1;
        chk("t4_afull_wren", bus_if.fifo_wren_o, 1'b1);
        chk("t4_afull_block", bus_if.hit_ready_o, 1'b0);
        tick();
        bus_if.fifo_full_i = 1'b1;
        #1;
        chk("t4_full_block", bus_if.hit_ready_o, 1'b0);
        tick();
        bus_if.fifo_full_i  = 1'b0;
        bus_if.fifo_afull_i = 1'b0;
        #1;
        chk("t4_resume", bus_if.hit_ready_o, 1'b1);
        tick();
        bus_if.hit_valid_i = 1'b0;
        tick();
        chk("t4_inflight2", inflight, 3'd2);
        chk("t4_err", err, 1'b0);

        // Simultaneous write and rlast at inflight 2, then underflow
        bus_if.hit_valid_i = 1'b1;
        bus_if.hit_data_i  = mk(6'd40, 32'hE0);
        #1;
        chk("t5_grant", bus_if.hit_ready_o, 1'b1);
        tick();
        bus_if.hit_valid_i = 1'b0;
        set_rl(1'b1);
        tick();
        chk("t5_inflight_same", inflight, 3'd2);
        repeat (2) tick();
        set_rl(1'b0);
        chk("t5_inflight0", inflight, 3'd0);
        chk("t5_err_clean", err, 1'b0);
        set_rl(1'b1);
        tick();
        set_rl(1'b0);
        chk("t5_underflow_cnt", inflight, 3'd0);
        chk("t5_underflow_err", err, 1'b1);

        // Misaligned offset 13 after a clean reset, then reset while busy
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_err_cleared", err, 1'b0);
        d13 = mk(6'd13, 32'h1313_1313);
        bus_if.hit_valid_i = 1'b1;
        bus_if.hit_data_i  = d13;
        #1;
        chk("t6_grant13", bus_if.hit_ready_o, 1'b1);
        tick();
        bus_if.hit_data_i = mk(6'd0, 32'hF1);
        chk("t6_wren13", bus_if.fifo_wren_o, 1'b1);
        chk("t6_wdata13", bus_if.fifo_wdata_o, d13);
        chk("t6_err13", err, 1'b1);
        tick();
        bus_if.hit_data_i = mk(6'd0, 32'hF2);
        tick();
        bus_if.hit_data_i = mk(6'd0, 32'hF3);
        #1;
        chk("t6_grant4", bus_if.hit_ready_o, 1'b1);
        tick();
        bus_if.hit_valid_i = 1'b0;
        chk("t6_busy_wren", bus_if.fifo_wren_o, 1'b1);
        chk("t6_busy_inflight", inflight, 3'd3);
        rst = 1'b1;
        tick();
        chk("t6_rst_wren", bus_if.fifo_wren_o, 1'b0);
        chk("t6_rst_inflight", inflight, 3'd0);
        chk("t6_rst_err", err, 1'b0);
        chk("t6_rst_idle", idle, 1'b1);
        rst = 1'b0;
        bus_if.hit_valid_i  = 1'b1;
        bus_if.miss_valid_i = 1'b1;
        #1;
        chk("t6_tie_hit", bus_if.hit_ready_o, 1'b1);
        chk("t6_tie_miss", bus_if.miss_ready_o, 1'b0);
        bus_if.hit_valid_i  = 1'b0;
        bus_if.miss_valid_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
